// File: rtl/spi_fpga_master_ctrl.sv
// SPI master for one fixed-length package per request: CS framing, SCLK generation,
// MOSI shifting and MISO capture, with configurable mode, bit order and clock divider.
module spi_fpga_master_ctrl #(
  parameter int CPHA                       = 1,
  parameter int CPOL                       = 1,
  parameter int PACK_LENGTH                = 8,
  parameter int PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int PACK_BIT_SEQUENCE_RECEIVE  = 1,
  parameter int CLK_DIV                    = 2
) (
  input  logic                   IN_CLK,
  input  logic                   IN_RESET,
  input  logic                   IN_START,
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   MISO,
  output logic                   SCLK,
  output logic                   MOSI,
  output logic                   CS,
  output logic                   OUT_BUSY,
  output logic                   OUT_DONE,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic [1:0]             o_dbg_state
);

  localparam int             EW        = $clog2(2 * PACK_LENGTH) + 1;
  localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * PACK_LENGTH - 1);
  localparam logic [7:0]     DIV_END   = 8'(CLK_DIV - 1);
  localparam logic           P_CPOL    = (CPOL != 0);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_LAG} state_t;

  function automatic logic [PACK_LENGTH-1:0] bit_rev(input logic [PACK_LENGTH-1:0] d);
    logic [PACK_LENGTH-1:0] r;
    for (int i = 0; i < PACK_LENGTH; i++) r[i] = d[PACK_LENGTH-1-i];
    return r;
  endfunction

  state_t                 r_state, w_state_nxt;
  logic                   r_sclk, r_mosi, r_cs, r_busy, r_done;
  logic                   w_sclk_nxt, w_mosi_nxt, w_cs_nxt, w_busy_nxt, w_done_nxt;
  logic [PACK_LENGTH-1:0] r_tx, r_rx, r_rx_out;
  logic [PACK_LENGTH-1:0] w_tx_nxt, w_rx_nxt, w_rx_out_nxt, w_tx_load, w_rx_final;
  logic [7:0]             r_div, w_div_nxt;
  logic [EW-1:0]          r_edge, w_edge_nxt;
  logic                   w_tick, w_edge_act, w_lead;

  // Handshake: IN_START is accepted only in IDLE outside the OUT_DONE cycle; OUT_BUSY
  // covers the whole package including the OUT_DONE cycle, after which a new start may land.
  assign w_tx_load  = (PACK_BIT_SEQUENCE_TRANSMIT != 0) ? IN_TRANSMIT_DATA : bit_rev(IN_TRANSMIT_DATA);
  assign w_rx_final = (PACK_BIT_SEQUENCE_RECEIVE != 0) ? r_rx : bit_rev(r_rx);
  assign w_tick     = (r_div == DIV_END);

  always_ff @(posedge IN_CLK or negedge IN_RESET) begin
    if (!IN_RESET) begin
      r_state  <= S_IDLE;
      r_sclk   <= P_CPOL;
      r_mosi   <= 1'b0;
      r_cs     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rx_out <= '0;
      r_div    <= '0;
      r_edge   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sclk   <= w_sclk_nxt;
      r_mosi   <= w_mosi_nxt;
      r_cs     <= w_cs_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_tx     <= w_tx_nxt;
      r_rx     <= w_rx_nxt;
      r_rx_out <= w_rx_out_nxt;
      r_div    <= w_div_nxt;
      r_edge   <= w_edge_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sclk_nxt   = r_sclk;
    w_mosi_nxt   = r_mosi;
    w_cs_nxt     = r_cs;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_tx_nxt     = r_tx;
    w_rx_nxt     = r_rx;
    w_rx_out_nxt = r_rx_out;
    w_div_nxt    = r_div;
    w_edge_nxt   = r_edge;
    w_edge_act   = 1'b0;
    w_lead       = ~r_edge[0];
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (IN_START && !r_done) begin
          w_state_nxt = S_LEAD;
          w_cs_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_div_nxt   = '0;
          w_edge_nxt  = '0;
          w_rx_nxt    = '0;
          if (CPHA == 0) begin
            w_mosi_nxt = w_tx_load[PACK_LENGTH-1];
            w_tx_nxt   = w_tx_load << 1;
          end else begin
            w_mosi_nxt = 1'b0;
            w_tx_nxt   = w_tx_load;
          end
        end
      end
      S_LEAD: begin
        if (w_tick) begin
          w_div_nxt   = '0;
          w_edge_act  = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          w_div_nxt  = '0;
          w_edge_act = 1'b1;
          if (r_edge == LAST_EDGE) w_state_nxt = S_LAG;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      default: begin
        if (w_tick) begin
          w_div_nxt    = '0;
          w_state_nxt  = S_IDLE;
          w_cs_nxt     = 1'b1;
          w_mosi_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_rx_out_nxt = w_rx_final;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
    endcase
    // Even edge count before the toggle means this is a leading edge.
    if (w_edge_act) begin
      w_sclk_nxt = ~r_sclk;
      w_edge_nxt = r_edge + 1'b1;
      if ((CPHA == 0) == w_lead) begin
        w_rx_nxt = {r_rx[PACK_LENGTH-2:0], MISO};
      end else if (r_edge != LAST_EDGE) begin
        w_mosi_nxt = r_tx[PACK_LENGTH-1];
        w_tx_nxt   = r_tx << 1;
      end
    end
  end

  assign SCLK             = r_sclk;
  assign MOSI             = r_mosi;
  assign CS               = r_cs;
  assign OUT_BUSY         = r_busy;
  assign OUT_DONE         = r_done;
  assign OUT_RECEIVE_DATA = r_rx_out;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_spi_fpga_master_ctrl.sv
// Bench for spi_fpga_master_ctrl: three instances (mode 3 loopback, mode 0 with a slave
// model, LSB-first loopback at CLK_DIV=1) driven from a vector table plus corner sequences.
module tb_spi_fpga_master_ctrl;

  localparam int CD_T[3]   = '{2, 2, 1};
  localparam int CPOL_T[3] = '{1, 0, 1};
  localparam int CPHA_T[3] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [7:0] txd [3] = '{8'h00, 8'h00, 8'h00};
  wire  [2:0] sclk_v, mosi_v, cs_v, busy_v, done_v;
  wire  [7:0] rx0, rx1, rx2;
  wire  [1:0] dbg0, dbg1, dbg2;
  logic       miso_b = 1'b0;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    int         dut;
    logic [7:0] tx;
    logic [7:0] slave;
    logic [7:0] exp_rx;
    logic [7:0] exp_seq;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  spi_fpga_master_ctrl u_a (
    .IN_CLK(clk), .IN_RESET(rst_n), .IN_START(start_v[0]), .IN_TRANSMIT_DATA(txd[0]),
    .MISO(mosi_v[0]), .SCLK(sclk_v[0]), .MOSI(mosi_v[0]), .CS(cs_v[0]), .OUT_BUSY(busy_v[0]),
    .OUT_DONE(done_v[0]), .OUT_RECEIVE_DATA(rx0), .o_dbg_state(dbg0));

  spi_fpga_master_ctrl #(.CPHA(0), .CPOL(0)) u_b (
    .IN_CLK(clk), .IN_RESET(rst_n), .IN_START(start_v[1]), .IN_TRANSMIT_DATA(txd[1]),
    .MISO(miso_b), .SCLK(sclk_v[1]), .MOSI(mosi_v[1]), .CS(cs_v[1]), .OUT_BUSY(busy_v[1]),
    .OUT_DONE(done_v[1]), .OUT_RECEIVE_DATA(rx1), .o_dbg_state(dbg1));

  spi_fpga_master_ctrl #(.PACK_BIT_SEQUENCE_TRANSMIT(0), .PACK_BIT_SEQUENCE_RECEIVE(0),
                         .CLK_DIV(1)) u_c (
    .IN_CLK(clk), .IN_RESET(rst_n), .IN_START(start_v[2]), .IN_TRANSMIT_DATA(txd[2]),
    .MISO(mosi_v[2]), .SCLK(sclk_v[2]), .MOSI(mosi_v[2]), .CS(cs_v[2]), .OUT_BUSY(busy_v[2]),
    .OUT_DONE(done_v[2]), .OUT_RECEIVE_DATA(rx2), .o_dbg_state(dbg2));

  // Mode-0 slave: first bit ready while CS is high, next bit after each falling SCLK.
  logic [7:0] s_word = 8'h00;
  int         s_idx = 0;
  logic       s_prev = 1'b0;
  always @(negedge clk) begin
    if (cs_v[1]) begin
      s_idx  = 0;
      miso_b = s_word[7];
    end else if (s_prev && !sclk_v[1]) begin
      s_idx = s_idx + 1;
      if (s_idx < 8) miso_b = s_word[7-s_idx];
    end
    s_prev = sclk_v[1];
  end

  function automatic logic [7:0] rx_of(input int d);
    case (d)
      0:       return rx0;
      1:       return rx1;
      default: return rx2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s actual=%h required=<no expected entry>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'h0, act}, {24'h0, e});
    end
  endtask

  task automatic xfer(input int d, input logic [7:0] tx, input logic [7:0] exp_rx,
                      input logic [7:0] exp_seq);
    int         dk, edges, n_done, bad, rx_chg, first_done;
    logic       prev, cpol;
    logic [7:0] seq, rx_before;
    dk   = 1 + 17 * CD_T[d];
    cpol = (CPOL_T[d] != 0);
    exp_q.push_back(exp_rx);
    @(negedge clk);
    start_v[d] = 1'b1;
    txd[d]     = tx;
    rx_before  = rx_of(d);
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    txd[d]     = ~tx;
    edges = 0; n_done = 0; bad = 0; rx_chg = 0; first_done = 0; seq = '0; prev = cpol;
    for (int k = 1; k <= dk + 2; k++) begin
      @(negedge clk);
      if (k == 1) check($sformatf("d%0d_first_mosi", d), {31'h0, mosi_v[d]},
                        {31'h0, (CPHA_T[d] == 0) ? exp_seq[7] : 1'b0});
      if (sclk_v[d] !== prev) begin
        edges++;
        if ((CPHA_T[d] == 0) == (sclk_v[d] != cpol)) seq = {seq[6:0], mosi_v[d]};
      end
      prev = sclk_v[d];
      if (k < dk) begin
        if (cs_v[d] !== 1'b0 || busy_v[d] !== 1'b1 || done_v[d] !== 1'b0) bad++;
        if (rx_of(d) !== rx_before) rx_chg++;
      end
      if (done_v[d] === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = k;
        pop_check($sformatf("d%0d_rx_data", d), rx_of(d));
        check($sformatf("d%0d_done_cs_mosi_busy", d), {29'h0, cs_v[d], mosi_v[d], busy_v[d]}, 32'h5);
      end
      if (k == dk + 1) check($sformatf("d%0d_after_done_cs_busy", d), {30'h0, cs_v[d], busy_v[d]}, 32'h2);
    end
    check($sformatf("d%0d_done_cycle", d), first_done, dk);
    check($sformatf("d%0d_done_pulses", d), n_done, 1);
    check($sformatf("d%0d_sclk_edges", d), edges, 16);
    check($sformatf("d%0d_mosi_seq", d), {24'h0, seq}, {24'h0, exp_seq});
    check($sformatf("d%0d_active_window", d), bad, 0);
    check($sformatf("d%0d_rx_held", d), rx_chg, 0);
    check($sformatf("d%0d_sclk_idle", d), {31'h0, sclk_v[d]}, {31'h0, cpol});
  endtask

  initial begin
    int   d1, d2, edges, dn;
    logic prev;

    vecs[0]  = '{0, 8'hA5, 8'h00, 8'hA5, 8'hA5};
    vecs[1]  = '{0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{0, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    vecs[3]  = '{0, 8'h3C, 8'h00, 8'h3C, 8'h3C};
    vecs[4]  = '{0, 8'h80, 8'h00, 8'h80, 8'h80};
    vecs[5]  = '{1, 8'h81, 8'h3C, 8'h3C, 8'h81};
    vecs[6]  = '{1, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[7]  = '{1, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[8]  = '{2, 8'h01, 8'h00, 8'h01, 8'h80};
    vecs[9]  = '{2, 8'h80, 8'h00, 8'h80, 8'h01};
    vecs[10] = '{2, 8'h96, 8'h00, 8'h96, 8'h69};

    // Power-up reset state, checked both during and after reset.
    repeat (3) @(negedge clk);
    check("rst_sclk", {29'h0, sclk_v}, 32'h5);
    check("rst_cs", {29'h0, cs_v}, 32'h7);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_mosi_busy_done", {23'h0, mosi_v, busy_v, done_v}, 32'h0);
    check("idle_rx", {8'h0, rx0, rx1, rx2}, 32'h0);
    check("idle_state", {26'h0, dbg0, dbg1, dbg2}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].dut == 1) s_word = vecs[i].slave;
      xfer(vecs[i].dut, vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_seq);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // Start held high: one IDLE cycle between packages, no acceptance while busy.
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    start_v[0] = 1'b1;
    txd[0]     = 8'h3C;
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 120 && d2 == 0; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) begin
        if (d1 == 0) d1 = k;
        else begin
          d2 = k;
          start_v[0] = 1'b0;
        end
        pop_check("b2b_rx_data", rx0);
      end
      if (d1 != 0 && k == d1 + 1) check("b2b_gap_cs_busy", {30'h0, cs_v[0], busy_v[0]}, 32'h2);
      if (d1 != 0 && k == d1 + 2) check("b2b_restart_cs_busy", {30'h0, cs_v[0], busy_v[0]}, 32'h1);
    end
    start_v[0] = 1'b0;
    check("b2b_first_done", d1, 35);
    check("b2b_done_spacing", d2 - d1, 36);
    repeat (3) @(negedge clk);

    // Reset one cycle after the 5th SCLK edge aborts without a done pulse.
    @(negedge clk);
    start_v[0] = 1'b1;
    txd[0]     = 8'h77;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    edges = 0; prev = 1'b1;
    for (int k = 0; k < 40 && edges < 5; k++) begin
      @(negedge clk);
      if (sclk_v[0] !== prev) edges++;
      prev = sclk_v[0];
    end
    check("abort_edges_seen", edges, 5);
    rst_n = 1'b0;
    #1;
    check("abort_cs_sclk_busy_done", {28'h0, cs_v[0], sclk_v[0], busy_v[0], done_v[0]}, 32'hC);
    check("abort_state_rx", {22'h0, dbg0, rx0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || cs_v[0] !== 1'b1) dn++;
    end
    check("abort_no_done", dn, 0);
    xfer(0, 8'h5A, 8'h5A, 8'h5A);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
